axi_sram_rd_slave: RTL and testbench

AXI4-style read responder that serves read bursts from an internal word-addressed SRAM array.
It is the target side of the core's AR/R read channel and drives ARREADY, RVALID, RDATA, RRESP and RLAST.
A backdoor write port preloads or modifies the array, for program images in simulation and for a future write responder.
It sits behind the fetch and LSU read initiators as the default main-memory model.

---
 rtl/axi_pkg.sv | 14 +
 rtl/sram_1r1w.sv | 27 ++
 rtl/axi_sram_rd_slave.sv | 146 ++++++++++++++
 tb/tb_axi_sram_rd_slave.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared definitions for the AXI read-side memory models.
package axi_pkg;

  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [31:0] MEM_BASE    = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DATA
  } rd_state_t;

endpackage

// File: rtl/sram_1r1w.sv
// Single-port-read, single-port-write word array; synchronous read, read-first on collisions.
module sram_1r1w #(
  parameter int unsigned DataW = 64,
  parameter int unsigned Depth = 4096,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i
);

  logic [DataW-1:0] mem [Depth];
  logic [DataW-1:0] rdata_q;

  // Non-blocking write and read on the same edge return the pre-write word.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/axi_sram_rd_slave.sv
// AXI4 read responder serving INCR bursts from an internal SRAM, with a backdoor write port.
module axi_sram_rd_slave
  import axi_pkg::*;
#(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned DEPTH     = 4096,
  parameter logic [31:0] BASE_ADDR = MEM_BASE,
  parameter int unsigned LATENCY   = 2
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              ARVALID,
  output logic              ARREADY,
  input  logic [31:0]       ARADDR,
  input  logic [7:0]        ARLEN,
  input  logic [2:0]        ARPROT,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              RLAST,
  input  logic              bd_we,
  input  logic [31:0]       bd_addr,
  input  logic [DATA_W-1:0] bd_wdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  rd_state_t   state_q;
  logic [28:0] idx_q;
  logic [7:0]  len_q;
  logic [7:0]  beat_q;
  logic [CW-1:0] cnt_q;
  logic        arready_q;
  logic        rvalid_q;
  logic        rlast_q;
  logic [1:0]  rresp_q;
  logic        ok_q;

  logic        ar_hs;
  logic        r_hs;
  logic        load;
  logic [7:0]  ld_beat;
  logic [29:0] ld_word;
  logic        ld_ok;
  logic [31:0] ar_off;
  logic [31:0] bd_off;
  logic        bd_ok;
  logic [DATA_W-1:0] sram_rdata;
  logic        unused_bits;

  assign ar_hs   = ARVALID & arready_q;
  assign r_hs    = rvalid_q & RREADY;
  assign load    = ((state_q == WAIT) && (cnt_q == '0)) ||
                   ((state_q == DATA) && r_hs && !rlast_q);
  assign ld_beat = (state_q == DATA) ? 8'(beat_q + 8'd1) : 8'd0;
  // Index is widened by one bit so a burst never wraps back into the array.
  assign ld_word = {1'b0, idx_q} + 30'(ld_beat);
  assign ld_ok   = ld_word < 30'(DEPTH);

  // Addresses below the base wrap to huge indices and fall out of range.
  assign ar_off = ARADDR - BASE_ADDR;
  assign bd_off = bd_addr - BASE_ADDR;
  assign bd_ok  = bd_off[31:3] < 29'(DEPTH);

  assign unused_bits = ^{ARPROT, ar_off[2:0], bd_off[2:0]};

  sram_1r1w #(
    .DataW (DATA_W),
    .Depth (DEPTH)
  ) u_sram (
    .clk_i   (ACLK),
    .re_i    (load),
    .raddr_i (ld_word[AW-1:0]),
    .rdata_o (sram_rdata),
    .we_i    (bd_we & bd_ok),
    .waddr_i (bd_off[AW+2:3]),
    .wdata_i (bd_wdata)
  );

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      ok_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          arready_q <= 1'b1;
          if (ar_hs) begin
            idx_q     <= ar_off[31:3];
            len_q     <= ARLEN;
            beat_q    <= '0;
            cnt_q     <= CNT_INIT;
            arready_q <= 1'b0;
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (ld_beat == len_q);
            rresp_q  <= ld_ok ? RESP_OKAY : RESP_DECERR;
            ok_q     <= ld_ok;
            state_q  <= DATA;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        DATA: begin
          if (r_hs) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              arready_q <= 1'b1;
              state_q   <= IDLE;
            end else begin
              beat_q  <= ld_beat;
              rlast_q <= (ld_beat == len_q);
              rresp_q <= ld_ok ? RESP_OKAY : RESP_DECERR;
              ok_q    <= ld_ok;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;
  // The SRAM output register only changes on beat loads, so the held beat stays stable.
  assign RDATA   = ok_q ? sram_rdata : '0;

endmodule

// File: tb/tb_axi_sram_rd_slave.sv
// Scoreboard bench for axi_sram_rd_slave: directed bursts, stalls, range edges, reset, backdoor.
module tb_axi_sram_rd_slave;

  typedef struct {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        ARVALID, ARREADY;
  logic [31:0] ARADDR;
  logic [7:0]  ARLEN;
  logic        RVALID, RREADY, RLAST;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        bd_we;
  logic [31:0] bd_addr;
  logic [63:0] bd_wdata;

  logic        arvalid1, arready1, rvalid1, rlast1;
  logic [31:0] araddr1;
  logic [7:0]  arlen1;
  logic [63:0] rdata1;
  logic [1:0]  rresp1;

  beat_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  logic        rr_hold = 1'b0;
  int          rr_len  = 0;
  logic [15:0] rr_pat  = '0;

  always #5 ACLK = ~ACLK;

  axi_sram_rd_slave #(.LATENCY(2)) dut (
    .ACLK (ACLK), .ARESET (ARESET),
    .ARVALID (ARVALID), .ARREADY (ARREADY), .ARADDR (ARADDR), .ARLEN (ARLEN),
    .ARPROT (3'b000),
    .RVALID (RVALID), .RREADY (RREADY), .RDATA (RDATA), .RRESP (RRESP), .RLAST (RLAST),
    .bd_we (bd_we), .bd_addr (bd_addr), .bd_wdata (bd_wdata)
  );

  axi_sram_rd_slave #(.LATENCY(1)) dut1 (
    .ACLK (ACLK), .ARESET (ARESET),
    .ARVALID (arvalid1), .ARREADY (arready1), .ARADDR (araddr1), .ARLEN (arlen1),
    .ARPROT (3'b010),
    .RVALID (rvalid1), .RREADY (RREADY), .RDATA (rdata1), .RRESP (rresp1), .RLAST (rlast1),
    .bd_we (bd_we), .bd_addr (bd_addr), .bd_wdata (bd_wdata)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input logic [1:0] r, input logic l);
    beat_t e;
    e.data = d;
    e.resp = r;
    e.last = l;
    sb.push_back(e);
  endtask

  task automatic bd_write(input int unsigned w, input logic [63:0] d);
    bd_we    = 1'b1;
    bd_addr  = 32'h8000_0000 + w * 8;
    bd_wdata = d;
    tick();
    bd_we    = 1'b0;
  endtask

  task automatic issue_ar(input logic [31:0] a, input logic [7:0] len);
    int n = 0;
    ARVALID = 1'b1;
    ARADDR  = a;
    ARLEN   = len;
    while (!ARREADY && n < 50) begin
      tick();
      n++;
    end
    if (!ARREADY) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ar_timeout: ARREADY stayed %b, expected 1", ARREADY);
    end
    tick();
    ARVALID = 1'b0;
  endtask

  task automatic wait_rvalid();
    int n = 0;
    while (!RVALID && n < 20) begin
      tick();
      n++;
    end
    chk("rvalid_wait", RVALID, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || RVALID) && n < 100) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    chk("drain_rvalid", RVALID, 0);
    tick();
  endtask

  // RREADY driver: forced low, always high, or a pattern that advances on RVALID cycles.
  initial begin
    int pos = 0;
    RREADY = 1'b1;
    forever begin
      tick();
      if (rr_hold) begin
        RREADY = 1'b0;
      end else if (rr_len == 0) begin
        RREADY = 1'b1;
        pos = 0;
      end else begin
        RREADY = rr_pat[pos];
        if (RVALID) pos = (pos + 1) % rr_len;
      end
    end
  end

  // Monitor: stability while stalled, and in-order compare on each handshake.
  initial begin
    beat_t held;
    beat_t e;
    logic stalled = 1'b0;
    forever begin
      @(negedge ACLK);
      if (ARESET) begin
        stalled = 1'b0;
        continue;
      end
      if (stalled) begin
        chk("stall_rvalid", RVALID, 1);
        chk("stall_rdata", RDATA, held.data);
        chk("stall_rresp", RRESP, held.resp);
        chk("stall_rlast", RLAST, held.last);
      end
      if (RVALID && RREADY) begin
        stalled = 1'b0;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got data %h, expected no beat", RDATA);
        end else begin
          e = sb.pop_front();
          chk("beat_rdata", RDATA, e.data);
          chk("beat_rresp", RRESP, e.resp);
          chk("beat_rlast", RLAST, e.last);
        end
      end else if (RVALID) begin
        stalled   = 1'b1;
        held.data = RDATA;
        held.resp = RRESP;
        held.last = RLAST;
      end else begin
        stalled = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    ARESET = 1'b1;
    ARVALID = 1'b0; ARADDR = '0; ARLEN = '0;
    arvalid1 = 1'b0; araddr1 = '0; arlen1 = '0;
    bd_we = 1'b0; bd_addr = '0; bd_wdata = '0;
    repeat (3) tick();
    chk("rst_arready", ARREADY, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_rlast", RLAST, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    ARESET = 1'b0;
    chk("rel_arready_pre", ARREADY, 0);
    tick();
    chk("rel_arready_post", ARREADY, 1);

    // Single beat, LATENCY=2 timing.
    bd_write(0, 64'h1122334455667788);
    push(64'h1122334455667788, 2'b00, 1'b1);
    issue_ar(32'h8000_0000, 8'd0);
    chk("t1_arready_low", ARREADY, 0);
    chk("t1_rvalid_t0", RVALID, 0);
    tick();
    chk("t1_rvalid_t1", RVALID, 0);
    tick();
    chk("t1_rvalid_t2", RVALID, 1);
    tick();
    chk("t1_arready_back", ARREADY, 1);
    chk("t1_rvalid_done", RVALID, 0);

    // LATENCY=1 instance: RVALID one edge after acceptance.
    chk("l1_arready", arready1, 1);
    arvalid1 = 1'b1; araddr1 = 32'h8000_0000; arlen1 = 8'd0;
    tick();
    arvalid1 = 1'b0;
    chk("l1_arready_low", arready1, 0);
    chk("l1_rvalid_t0", rvalid1, 0);
    tick();
    chk("l1_rvalid_t1", rvalid1, 1);
    chk("l1_rdata", rdata1, 64'h1122334455667788);
    chk("l1_rresp", rresp1, 2'b00);
    chk("l1_rlast", rlast1, 1);
    tick();
    chk("l1_rvalid_done", rvalid1, 0);

    // Four-beat burst at full rate.
    for (int i = 0; i < 4; i++) bd_write(4 + i, 64'(i + 1));
    for (int i = 0; i < 4; i++) push(64'(i + 1), 2'b00, i == 3);
    issue_ar(32'h8000_0020, 8'd3);
    wait_rvalid();
    n = 0;
    while (RVALID && n < 20) begin
      tick();
      n++;
    end
    chk("t2_consecutive_beats", n, 4);
    drain();

    // Same burst with RREADY 1,0,0,1,1,0,1.
    rr_pat = 16'b0000_0000_0101_1001;
    rr_len = 7;
    for (int i = 0; i < 4; i++) push(64'(i + 1), 2'b00, i == 3);
    issue_ar(32'h8000_0020, 8'd3);
    drain();
    rr_len = 0;
    tick();

    // Burst crossing the top of the array, then an address below the base.
    bd_write(4094, 64'hAAAA_0000_0000_4094);
    bd_write(4095, 64'hBBBB_0000_0000_4095);
    push(64'hAAAA_0000_0000_4094, 2'b00, 1'b0);
    push(64'hBBBB_0000_0000_4095, 2'b00, 1'b0);
    push(64'h0, 2'b11, 1'b0);
    push(64'h0, 2'b11, 1'b1);
    issue_ar(32'h8000_0000 + (4094 << 3), 8'd3);
    drain();
    push(64'h0, 2'b11, 1'b1);
    issue_ar(32'h7FFF_FFF8, 8'd0);
    drain();

    // Reset while beat 2 of 4 is stalled.
    rr_pat = 16'h0001;
    rr_len = 8;
    push(64'd1, 2'b00, 1'b0);
    issue_ar(32'h8000_0020, 8'd3);
    wait_rvalid();
    tick();
    tick();
    #2;
    ARESET = 1'b1;
    #1;
    chk("rst_mid_rvalid", RVALID, 0);
    chk("rst_mid_arready", ARREADY, 0);
    chk("rst_mid_rlast", RLAST, 0);
    @(posedge ACLK);
    #1;
    chk("rst_mid_arready_hold", ARREADY, 0);
    ARESET = 1'b0;
    rr_len = 0;
    tick();
    chk("rst_mid_arready_rel", ARREADY, 1);
    chk("rst_mid_no_pending", sb.size(), 0);
    for (int i = 0; i < 4; i++) push(64'(i + 1), 2'b00, i == 3);
    issue_ar(32'h8000_0020, 8'd3);
    drain();

    // Backdoor write to the word held in RDATA during a stall.
    rr_hold = 1'b1;
    push(64'd3, 2'b00, 1'b1);
    issue_ar(32'h8000_0030, 8'd0);
    wait_rvalid();
    bd_write(6, 64'hDEAD_BEEF_0000_0006);
    tick();
    chk("bd_rdata_held", RDATA, 64'd3);
    rr_hold = 1'b0;
    drain();
    push(64'hDEAD_BEEF_0000_0006, 2'b00, 1'b1);
    issue_ar(32'h8000_0030, 8'd0);
    drain();

    chk("sb_empty_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
